// File: rtl/uartlite_slave.sv
// AXI4-Lite UARTLite register model (RX 0x0, TX 0x4, STAT 0x8, CTRL 0xC) with byte-stream PHY side.
// Latency: B one cycle after the later of AW/W; R one cycle after AR; TX head is combinational to tx_out_data.
// Backpressure: one write and one read in flight; RX input cannot be stalled (drops set overrun).
// Optional interrupt logic is built when UARTLITE_SLAVE_IRQ_EN is defined.

module uartlite_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push & ~do_pop)      cnt <= cnt + (AW+1)'(1);
      else if (do_pop & ~do_push) cnt <= cnt - (AW+1)'(1);
    end
  end
endmodule

module uartlite_slave #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [3:0]  axi_awaddr,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [3:0]  axi_araddr,
  input  logic [2:0]  axi_arprot,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        tx_out_valid,
  input  logic        tx_out_ready,
  output logic [7:0]  tx_out_data,
  input  logic        rx_in_valid,
  input  logic [7:0]  rx_in_data,
  output logic        interrupt
);
  logic       run;
  logic       aw_lat, w_lat, w_strb_q;
  logic [1:0] aw_addr_q, wr_addr;
  logic [7:0] w_data_q, wr_data, tx_head, rx_head, stat, rd_byte;
  logic       wr_strb, aw_hs, w_hs, commit, ar_hs;
  logic       tx_push, tx_pop, tx_clr, tx_empty, tx_full;
  logic       rx_pop, rx_clr, rx_empty, rx_full;
  logic       ctrl_wr, stat_rd, ovr, ie;
  logic       unused_ok;

  assign unused_ok = ^{axi_awaddr[1:0], axi_araddr[1:0], axi_awprot, axi_arprot,
                       axi_wdata[31:8], axi_wstrb[3:1]};

  // Readies stay low until the first edge after reset release.
  assign axi_awready = run & ~aw_lat & ~axi_bvalid;
  assign axi_wready  = run & ~w_lat & ~axi_bvalid;
  assign axi_arready = run & ~axi_rvalid;
  assign axi_bresp   = 2'b00;
  assign axi_rresp   = 2'b00;

  assign aw_hs   = axi_awvalid & axi_awready;
  assign w_hs    = axi_wvalid & axi_wready;
  assign ar_hs   = axi_arvalid & axi_arready;
  assign wr_addr = aw_lat ? aw_addr_q : axi_awaddr[3:2];
  assign wr_data = w_lat ? w_data_q : axi_wdata[7:0];
  assign wr_strb = w_lat ? w_strb_q : axi_wstrb[0];
  assign commit  = (aw_lat | aw_hs) & (w_lat | w_hs);

  assign tx_push = commit & wr_strb & (wr_addr == 2'd1);
  assign ctrl_wr = commit & wr_strb & (wr_addr == 2'd3);
  assign tx_clr  = ctrl_wr & wr_data[0];
  assign rx_clr  = ctrl_wr & wr_data[1];
  assign tx_pop  = tx_out_valid & tx_out_ready;
  assign rx_pop  = ar_hs & (axi_araddr[3:2] == 2'd0);
  assign stat_rd = ar_hs & (axi_araddr[3:2] == 2'd2);

  assign tx_out_valid = ~tx_empty;
  assign tx_out_data  = tx_empty ? 8'd0 : tx_head;
  assign stat = {2'b00, ovr, ie, tx_full, tx_empty, rx_full, ~rx_empty};

  always_comb begin
    rd_byte = 8'd0;
    case (axi_araddr[3:2])
      2'd0:    rd_byte = rx_empty ? 8'd0 : rx_head;
      2'd2:    rd_byte = stat;
      default: rd_byte = 8'd0;
    endcase
  end

  uartlite_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rstn(rstn), .clr(tx_clr), .push(tx_push), .pop(tx_pop),
    .din(wr_data), .head(tx_head), .empty(tx_empty), .full(tx_full)
  );

  uartlite_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rstn(rstn), .clr(rx_clr), .push(rx_in_valid), .pop(rx_pop),
    .din(rx_in_data), .head(rx_head), .empty(rx_empty), .full(rx_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run        <= 1'b0;
      aw_lat     <= 1'b0;
      w_lat      <= 1'b0;
      aw_addr_q  <= 2'd0;
      w_data_q   <= 8'd0;
      w_strb_q   <= 1'b0;
      axi_bvalid <= 1'b0;
      axi_rvalid <= 1'b0;
      axi_rdata  <= 32'd0;
      ovr        <= 1'b0;
    end else begin
      run <= 1'b1;
      if (commit) begin
        aw_lat     <= 1'b0;
        w_lat      <= 1'b0;
        axi_bvalid <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_lat    <= 1'b1;
          aw_addr_q <= axi_awaddr[3:2];
        end
        if (w_hs) begin
          w_lat    <= 1'b1;
          w_data_q <= axi_wdata[7:0];
          w_strb_q <= axi_wstrb[0];
        end
        if (axi_bready) axi_bvalid <= 1'b0;
      end
      if (ar_hs) begin
        axi_rvalid <= 1'b1;
        axi_rdata  <= {24'd0, rd_byte};
      end else if (axi_rready) begin
        axi_rvalid <= 1'b0;
      end
      // A fresh drop outranks the clear from a concurrent STAT read.
      if (rx_in_valid & rx_full & ~rx_pop) ovr <= 1'b1;
      else if (stat_rd)                    ovr <= 1'b0;
    end
  end

`ifdef UARTLITE_SLAVE_IRQ_EN
  logic prev_rx_ne, prev_tx_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ie            <= 1'b0;
      prev_rx_ne    <= 1'b0;
      prev_tx_empty <= 1'b1;
      interrupt     <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= wr_data[4];
      prev_rx_ne    <= ~rx_empty;
      prev_tx_empty <= tx_empty;
      interrupt     <= ie & ((~rx_empty & ~prev_rx_ne) | (tx_empty & ~prev_tx_empty));
    end
  end
`else
  assign ie        = 1'b0;
  assign interrupt = 1'b0;
`endif
endmodule

// File: tb/tb_uartlite_slave.sv
// Directed bench for uartlite_slave: AXI-Lite register accesses, TX stream drain, RX injection.
module tb_uartlite_slave;
  logic        clk = 0;
  logic        rstn = 0;
  logic        axi_awvalid = 0, axi_awready;
  logic [3:0]  axi_awaddr = 0;
  logic [2:0]  axi_awprot = 0;
  logic        axi_wvalid = 0, axi_wready;
  logic [31:0] axi_wdata = 0;
  logic [3:0]  axi_wstrb = 0;
  logic        axi_bvalid, axi_bready = 0;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid = 0, axi_arready;
  logic [3:0]  axi_araddr = 0;
  logic [2:0]  axi_arprot = 0;
  logic        axi_rvalid, axi_rready = 0;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        tx_out_valid, tx_out_ready = 0;
  logic [7:0]  tx_out_data;
  logic        rx_in_valid = 0;
  logic [7:0]  rx_in_data = 0;
  logic        interrupt;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];

  uartlite_slave #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .rstn(rstn),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .tx_out_valid(tx_out_valid), .tx_out_ready(tx_out_ready), .tx_out_data(tx_out_data),
    .rx_in_valid(rx_in_valid), .rx_in_data(rx_in_data), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [7:0] d, input logic [3:0] s, input bit aw_first);
    bit aw_done, w_done, w_sent;
    int n = 0;
    @(posedge clk); #1;
    axi_awvalid = 1; axi_awaddr = a; axi_wdata = {24'hABCDEF, d}; axi_wstrb = s;
    axi_wvalid = !aw_first;
    w_sent = !aw_first;
    while (axi_awvalid || axi_wvalid) begin
      @(negedge clk);
      aw_done = axi_awvalid && axi_awready;
      w_done  = axi_wvalid && axi_wready;
      @(posedge clk); #1;
      if (aw_done) axi_awvalid = 0;
      if (w_done) axi_wvalid = 0;
      if (!w_sent && aw_done) begin axi_wvalid = 1; w_sent = 1; end
      n++;
      if (n > 50) begin
        check("write_handshake_timeout", 1, 0);
        axi_awvalid = 0; axi_wvalid = 0;
      end
    end
    check("bvalid_after_w", {31'd0, axi_bvalid}, 1);
    check("bresp", {30'd0, axi_bresp}, 0);
    axi_bready = 1;
    @(posedge clk); #1;
    axi_bready = 0;
    check("bvalid_clear", {31'd0, axi_bvalid}, 0);
  endtask

  // Expected read data is queued at issue and compared when R arrives.
  task automatic axi_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bit ok = 0;
    logic [31:0] e;
    rd_q.push_back(exp);
    @(posedge clk); #1;
    axi_arvalid = 1; axi_araddr = a;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = axi_arready;
      @(posedge clk); #1;
    end
    axi_arvalid = 0;
    e = rd_q.pop_front();
    if (!ok) check({tag, "_ar_timeout"}, 0, 1);
    check({tag, "_rvalid"}, {31'd0, axi_rvalid}, 1);
    check(tag, axi_rdata, e);
    axi_rready = 1;
    @(posedge clk); #1;
    axi_rready = 0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    @(posedge clk); #1;
    rx_in_valid = 1; rx_in_data = d;
    @(posedge clk); #1;
    rx_in_valid = 0;
  endtask

  task automatic tx_drain(input string tag);
    int n = 0;
    @(posedge clk); #1;
    tx_out_ready = 1;
    while (tx_q.size() > 0 && n < 100) begin
      @(negedge clk);
      if (tx_out_valid) check(tag, {24'd0, tx_out_data}, {24'd0, tx_q.pop_front()});
      n++;
      if (tx_q.size() > 0) @(posedge clk);
    end
    @(posedge clk); #1;
    tx_out_ready = 0;
    check({tag, "_all_seen"}, tx_q.size(), 0);
    check({tag, "_empty_after"}, {31'd0, tx_out_valid}, 0);
    tx_q.delete();
  endtask

  initial begin
    int irq_hi;
    // Reset state
    #12;
    check("rst_awready", {31'd0, axi_awready}, 0);
    check("rst_wready", {31'd0, axi_wready}, 0);
    check("rst_arready", {31'd0, axi_arready}, 0);
    check("rst_bvalid", {31'd0, axi_bvalid}, 0);
    check("rst_rvalid", {31'd0, axi_rvalid}, 0);
    check("rst_rdata", axi_rdata, 0);
    check("rst_tx_valid", {31'd0, tx_out_valid}, 0);
    check("rst_tx_data", {24'd0, tx_out_data}, 0);
    check("rst_irq", {31'd0, interrupt}, 0);
    @(posedge clk); #1 rstn = 1;
    repeat (2) @(posedge clk);

    axi_read("stat_reset", 4'h8, 32'h04);

    // Single TX byte with AW leading W
    axi_write(4'h4, 8'h41, 4'h1, 1);
    check("tx_valid_one", {31'd0, tx_out_valid}, 1);
    check("tx_data_one", {24'd0, tx_out_data}, 32'h41);
    tx_q.push_back(8'h41);
    tx_drain("tx_one");

    // Fill TX, overfill, drain in order
    for (int i = 1; i <= 16; i++) begin
      axi_write(4'h4, 8'(i), 4'hF, 0);
      tx_q.push_back(8'(i));
    end
    axi_read("stat_tx_full", 4'h8, 32'h08);
    axi_write(4'h4, 8'h99, 4'h1, 0);
    axi_read("stat_tx_full2", 4'h8, 32'h08);
    tx_drain("tx_fill");

    // wstrb[0]=0 write is ignored; reads of TX/CTRL return 0
    axi_write(4'h4, 8'h77, 4'hE, 0);
    check("strb0_no_push", {31'd0, tx_out_valid}, 0);
    axi_read("rd_txfifo_zero", 4'h4, 32'h0);
    axi_read("rd_ctrl_zero", 4'hC, 32'h0);

    // RX path
    rx_push(8'h5A);
    rx_push(8'hC3);
    axi_read("stat_rx_ne", 4'h8, 32'h05);
    axi_read("rx_first", 4'h0, 32'h5A);
    axi_read("rx_second", 4'h0, 32'hC3);
    axi_read("rx_empty_read", 4'h0, 32'h0);
    axi_read("stat_rx_empty", 4'h8, 32'h04);

    // RX overrun
    for (int i = 0; i < 16; i++) rx_push(8'(8'h80 + i));
    axi_read("stat_rx_full", 4'h8, 32'h07);
    rx_push(8'hEE);
    axi_read("stat_overrun", 4'h8, 32'h27);
    axi_read("stat_ovr_clear", 4'h8, 32'h07);
    axi_read("rx_head_kept", 4'h0, 32'h80);

    // CTRL flush of both FIFOs
    axi_write(4'h4, 8'h33, 4'h1, 0);
    axi_write(4'hC, 8'h03, 4'h1, 1);
    check("flush_tx_valid", {31'd0, tx_out_valid}, 0);
    axi_read("stat_after_flush", 4'h8, 32'h04);

    // Interrupt enable and RX-arrival pulse
    axi_write(4'hC, 8'h10, 4'h1, 0);
`ifdef UARTLITE_SLAVE_IRQ_EN
    axi_read("stat_ie", 4'h8, 32'h14);
`else
    axi_read("stat_ie", 4'h8, 32'h04);
`endif
    irq_hi = 0;
    @(posedge clk); #1;
    rx_in_valid = 1; rx_in_data = 8'h11;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      rx_in_valid = 0;
      if (interrupt) irq_hi++;
    end
`ifdef UARTLITE_SLAVE_IRQ_EN
    check("irq_pulse_cycles", irq_hi, 1);
`else
    check("irq_tied_low", irq_hi, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
